// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU operation codes (also used by aludec) and datapath mux selects.
package mc_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_BEQ   = 3'b001;
    localparam logic [2:0] ALU_BNE   = 3'b011;
    localparam logic [2:0] ALU_RTYPE = 3'b100;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ,
            OP_BNE, OP_ADDI, OP_J: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath bundle. master = controller (takes op/flags,
// drives controls); slave = datapath side.
interface mc_control_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic [2:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, zero, mem_ready,
        output aluop, alusrca, alusrcb, pcsrc,
        output iord, memtoreg, regdst,
        output pcen, irwrite, regwrite, memwrite,
        output illegal_op, state
    );

    modport slave (
        output op, zero, mem_ready,
        input  aluop, alusrca, alusrcb, pcsrc,
        input  iord, memtoreg, regdst,
        input  pcen, irwrite, regwrite, memwrite,
        input  illegal_op, state
    );
endinterface

// File: rtl/mc_outdec.sv
// Combinational state -> datapath control decode. Inputs: state, zero,
// mem_ready, reset_n. Outputs: mux selects, aluop and write enables.
module mc_outdec
    import mc_control_pkg::*;
(
    input  state_t     state,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       reset_n,
    output logic [2:0] aluop,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite
);
    logic pcen_d, irwrite_d, regwrite_d, memwrite_d;

    always_comb begin
        aluop      = ALU_ADD;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        pcsrc      = PC_ALU;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        pcen_d     = 1'b0;
        irwrite_d  = 1'b0;
        regwrite_d = 1'b0;
        memwrite_d = 1'b0;
        case (state)
            S_FETCH: begin
                alusrcb   = SRCB_FOUR;
                irwrite_d = mem_ready;
                pcen_d    = mem_ready;
            end
            S_DECODE: alusrcb = SRCB_IMM4;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_d = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_d = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALU_RTYPE;
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_d = 1'b1;
            end
            // ALU folds the inequality for bne into zero, so both use zero
            S_BEQEX, S_BNEEX: begin
                alusrca = 1'b1;
                aluop   = (state == S_BEQEX) ? ALU_BEQ : ALU_BNE;
                pcsrc   = PC_ALUOUT;
                pcen_d  = zero;
            end
            S_ADDIWB: regwrite_d = 1'b1;
            S_JEX: begin
                pcsrc  = PC_JUMP;
                pcen_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are forced low during reset so no write can slip through
    assign pcen     = pcen_d     & reset_n;
    assign irwrite  = irwrite_d  & reset_n;
    assign regwrite = regwrite_d & reset_n;
    assign memwrite = memwrite_d & reset_n;
endmodule

// File: rtl/mc_control.sv
// Multicycle controller: state register + next-state logic; control
// decode in mc_outdec. Ports: clk, reset_n, bus (mc_control_if.master).
module mc_control
    import mc_control_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    mc_control_if.master bus
);
    state_t st;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st <= S_FETCH;
        end else begin
            case (st)
                S_FETCH:
                    if (bus.mem_ready) st <= S_DECODE;
                S_DECODE:
                    case (bus.op)
                        OP_LW, OP_SW: st <= S_MEMADR;
                        OP_R:         st <= S_RTYPEEX;
                        OP_BEQ:       st <= S_BEQEX;
                        OP_BNE:       st <= S_BNEEX;
                        OP_ADDI:      st <= S_ADDIEX;
                        OP_J:         st <= S_JEX;
                        default:      st <= S_FETCH;
                    endcase
                S_MEMADR:
                    st <= (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:
                    if (bus.mem_ready) st <= S_MEMWB;
                S_MEMWR:
                    if (bus.mem_ready) st <= S_FETCH;
                S_RTYPEEX: st <= S_RTYPEWB;
                S_ADDIEX:  st <= S_ADDIWB;
                default:   st <= S_FETCH;
            endcase
        end
    end

    assign bus.state      = st;
    assign bus.illegal_op = reset_n & (st == S_DECODE)
                          & ~op_legal(bus.op);

    mc_outdec u_outdec (
        .state     (st),
        .zero      (bus.zero),
        .mem_ready (bus.mem_ready),
        .reset_n   (reset_n),
        .aluop     (bus.aluop),
        .alusrca   (bus.alusrca),
        .alusrcb   (bus.alusrcb),
        .pcsrc     (bus.pcsrc),
        .iord      (bus.iord),
        .memtoreg  (bus.memtoreg),
        .regdst    (bus.regdst),
        .pcen      (bus.pcen),
        .irwrite   (bus.irwrite),
        .regwrite  (bus.regwrite),
        .memwrite  (bus.memwrite)
    );
endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: builds per-instruction expected
// cycle traces from the instruction semantics and compares every cycle.
module tb_mc_control;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       pcen;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        ctl_t c;
        logic rdy;
        logic rdy_care;
        logic zr;
        logic zr_care;
        logic op_care;
    } ent_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mc_control_if bus ();

    mc_control dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    ent_t q[$];
    logic [5:0] cur_op;

    function automatic ctl_t sample();
        ctl_t c;
        c.st       = bus.state;
        c.aluop    = bus.aluop;
        c.srca     = bus.alusrca;
        c.srcb     = bus.alusrcb;
        c.pcsrc    = bus.pcsrc;
        c.iord     = bus.iord;
        c.memtoreg = bus.memtoreg;
        c.regdst   = bus.regdst;
        c.pcen     = bus.pcen;
        c.irwrite  = bus.irwrite;
        c.regwrite = bus.regwrite;
        c.memwrite = bus.memwrite;
        c.illegal  = bus.illegal_op;
        return c;
    endfunction

    function automatic ctl_t at(input int s);
        ctl_t c = '0;
        c.st = 4'(s);
        return c;
    endfunction

    function automatic ent_t ent(input ctl_t c);
        ent_t e = '0;
        e.c = c;
        return e;
    endfunction

    function automatic bit known(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011,
                          6'b000100, 6'b000101, 6'b001000, 6'b000010};
    endfunction

    // Expected per-cycle trace of one instruction, from fetch to last step
    task automatic build(input logic [5:0] op, input logic zv,
                         input int fw, input int mw);
        ctl_t c;
        ent_t e;
        q.delete();
        cur_op = op;
        for (int i = 0; i < fw; i++) begin
            c = at(0); c.srcb = 2'b01;
            e = ent(c); e.rdy_care = 1'b1; e.rdy = 1'b0;
            q.push_back(e);
        end
        c = at(0); c.srcb = 2'b01; c.irwrite = 1'b1; c.pcen = 1'b1;
        e = ent(c); e.rdy_care = 1'b1; e.rdy = 1'b1;
        q.push_back(e);
        c = at(1); c.srcb = 2'b11; c.illegal = !known(op);
        e = ent(c); e.op_care = 1'b1;
        q.push_back(e);
        if (op == 6'b100011 || op == 6'b101011) begin
            c = at(2); c.srca = 1'b1; c.srcb = 2'b10;
            e = ent(c); e.op_care = 1'b1;
            q.push_back(e);
            for (int i = 0; i <= mw; i++) begin
                c = (op == 6'b100011) ? at(3) : at(5);
                c.iord = 1'b1;
                c.memwrite = (op == 6'b101011);
                e = ent(c); e.rdy_care = 1'b1; e.rdy = (i == mw);
                q.push_back(e);
            end
            if (op == 6'b100011) begin
                c = at(4); c.memtoreg = 1'b1; c.regwrite = 1'b1;
                q.push_back(ent(c));
            end
        end else if (op == 6'b000000) begin
            c = at(6); c.srca = 1'b1; c.aluop = 3'b100;
            q.push_back(ent(c));
            c = at(7); c.regdst = 1'b1; c.regwrite = 1'b1;
            q.push_back(ent(c));
        end else if (op == 6'b000100 || op == 6'b000101) begin
            c = (op == 6'b000100) ? at(8) : at(12);
            c.srca = 1'b1;
            c.aluop = (op == 6'b000100) ? 3'b001 : 3'b011;
            c.pcsrc = 2'b01; c.pcen = zv;
            e = ent(c); e.zr_care = 1'b1; e.zr = zv;
            q.push_back(e);
        end else if (op == 6'b001000) begin
            c = at(9); c.srca = 1'b1; c.srcb = 2'b10;
            q.push_back(ent(c));
            c = at(10); c.regwrite = 1'b1;
            q.push_back(ent(c));
        end else if (op == 6'b000010) begin
            c = at(11); c.pcsrc = 2'b10; c.pcen = 1'b1;
            q.push_back(ent(c));
        end
    endtask

    task automatic check(input string tag, input int step,
                         input ctl_t exp);
        ctl_t got;
        got = sample();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s step %0d: got %h expected %h",
                   tag, step, got, exp);
        end
    endtask

    // Entered at posedge+1; leaves at posedge+1 after n steps
    task automatic run(input string tag, input int n);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e = q[i];
            bus.op        = e.op_care  ? cur_op : 6'($urandom);
            bus.mem_ready = e.rdy_care ? e.rdy  : 1'($urandom);
            bus.zero      = e.zr_care  ? e.zr   : 1'($urandom);
            #4;
            check(tag, i, e.c);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic instr(input string tag, input logic [5:0] op,
                         input logic zv, input int fw, input int mw);
        build(op, zv, fw, mw);
        run(tag, q.size());
    endtask

    logic [5:0] legal_ops [7];
    ctl_t rst_exp;

    initial begin
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                      6'b000101, 6'b001000, 6'b000010};
        rst_exp = at(0);
        rst_exp.srcb = 2'b01;

        reset_n = 1'b0;
        bus.op = 6'b100011;
        bus.zero = 1'b1;
        bus.mem_ready = 1'b1;
        #3;
        check("reset_hold", 0, rst_exp);
        @(posedge clk);
        #1;
        check("reset_edge", 1, rst_exp);
        reset_n = 1'b1;

        instr("lw", 6'b100011, 1'b0, 0, 0);
        instr("sw_wait3", 6'b101011, 1'b0, 0, 3);
        instr("beq_taken", 6'b000100, 1'b1, 0, 0);
        instr("beq_not", 6'b000100, 1'b0, 0, 0);
        instr("bne_taken", 6'b000101, 1'b1, 1, 0);
        instr("rtype", 6'b000000, 1'b0, 0, 0);
        instr("illegal", 6'b111111, 1'b0, 0, 0);
        instr("addi", 6'b001000, 1'b0, 2, 0);
        instr("jump", 6'b000010, 1'b0, 0, 0);
        instr("lw_wait", 6'b100011, 1'b0, 1, 2);

        for (int k = 0; k < 40; k++) begin
            logic [5:0] op;
            int sel;
            sel = int'($urandom_range(0, 7));
            if (sel < 7) begin
                op = legal_ops[sel];
            end else begin
                do op = 6'($urandom); while (known(op));
            end
            instr("rand", op, 1'($urandom),
                  int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)));
        end

        // Reset asserted while a store waits on memory
        build(6'b101011, 1'b0, 0, 3);
        run("sw_pre_reset", 3);
        bus.op = 6'($urandom);
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        #2;
        check("sw_in_memwr", 3, q[3].c);
        reset_n = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check("reset_mid_memwr", 0, rst_exp);
        @(posedge clk);
        #1;
        check("reset_mid_hold", 1, rst_exp);
        reset_n = 1'b1;

        instr("after_reset_lw", 6'b100011, 1'b0, 0, 1);
        instr("after_reset_j", 6'b000010, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
